// File: rtl/core_pkg.sv
// Shared core types and sizing for the commit/retire slice.
package core_pkg;
    localparam int ISSUE_WIDTH     = 2;
    localparam int NUM_ARCH_REGS   = 32;
    localparam int ZERO_REG        = 31;
    localparam int ARCH_W          = 5;
    localparam int PREG_W          = 6;
    localparam int RESTORE_PER_CYC = 2;
    localparam int NUM_BEATS       = NUM_ARCH_REGS / RESTORE_PER_CYC;
    localparam int BEAT_W          = $clog2(NUM_BEATS);

    typedef logic [PREG_W-1:0] preg_tag_t;

    typedef enum logic [0:0] {CRU_RUN, CRU_RECOVER} cru_state_t;
endpackage

// File: rtl/arch_rat.sv
// Retirement RAT: NUM_ARCH_REGS x preg_tag_t, multi-port writes (higher slot wins),
// combinational old-tag lookups and indexed restore reads.
module arch_rat
    import core_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ISSUE_WIDTH-1:0]              we,
    input  logic [ISSUE_WIDTH*ARCH_W-1:0]       waddr,
    input  logic [ISSUE_WIDTH*PREG_W-1:0]       wdata,
    input  logic [ISSUE_WIDTH*ARCH_W-1:0]       raddr,
    output logic [ISSUE_WIDTH*PREG_W-1:0]       rdata,
    input  logic [RESTORE_PER_CYC*ARCH_W-1:0]   ridx,
    output logic [RESTORE_PER_CYC*PREG_W-1:0]   rtag
);
    preg_tag_t rat [NUM_ARCH_REGS];

    // Later loop iterations override earlier ones, so the youngest slot's write sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) rat[i] <= preg_tag_t'(i);
        end else begin
            for (int w = 0; w < ISSUE_WIDTH; w++) begin
                if (we[w]) rat[waddr[w*ARCH_W +: ARCH_W]] <= wdata[w*PREG_W +: PREG_W];
            end
        end
    end

    always_comb begin
        rdata = '0;
        rtag  = '0;
        for (int r = 0; r < ISSUE_WIDTH; r++)
            rdata[r*PREG_W +: PREG_W] = rat[raddr[r*ARCH_W +: ARCH_W]];
        for (int l = 0; l < RESTORE_PER_CYC; l++)
            rtag[l*PREG_W +: PREG_W] = rat[ridx[l*ARCH_W +: ARCH_W]];
    end
endmodule

// File: rtl/commit_retire_unit.sv
// Retires ROB commit bundles into the retirement RAT, frees superseded tags, and on a
// committing exception flushes and streams the retirement RAT back to rename.
module commit_retire_unit
    import core_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ISSUE_WIDTH-1:0]              commit_valid,
    input  logic [ISSUE_WIDTH*ARCH_W-1:0]       commit_arch_rd,
    input  logic [ISSUE_WIDTH*PREG_W-1:0]       commit_phys_rd,
    input  logic [ISSUE_WIDTH-1:0]              commit_exception,
    output logic [ISSUE_WIDTH-1:0]              free_valid,
    output logic [ISSUE_WIDTH*PREG_W-1:0]       free_tag,
    output logic                                flush_req,
    output logic                                recover_busy,
    output logic                                restore_valid,
    output logic [RESTORE_PER_CYC*ARCH_W-1:0]   restore_idx,
    output logic [RESTORE_PER_CYC*PREG_W-1:0]   restore_tag,
    output logic [31:0]                         retired_count,
    output logic                                dbg_state
);
    cru_state_t state_q, state_d;
    logic [BEAT_W-1:0]                      beat_q;
    logic [ISSUE_WIDTH-1:0]                 retire, rat_we;
    logic                                   exc_seen;
    logic [31:0]                            n_retire;
    logic [ISSUE_WIDTH*PREG_W-1:0]          rat_rdata, old_tag;
    logic [RESTORE_PER_CYC*ARCH_W-1:0]      ridx;
    logic [RESTORE_PER_CYC*PREG_W-1:0]      rtag;
    logic                                   last_beat_shown;

    arch_rat u_arch_rat (
        .clk   (clk),
        .reset (reset),
        .we    (rat_we),
        .waddr (commit_arch_rd),
        .wdata (commit_phys_rd),
        .raddr (commit_arch_rd),
        .rdata (rat_rdata),
        .ridx  (ridx),
        .rtag  (rtag)
    );

    // Beat counter has wrapped back to 0 after the final beat was put on the outputs.
    assign last_beat_shown = restore_valid && (beat_q == '0);
    assign dbg_state       = state_q;

    always_comb begin
        exc_seen = 1'b0;
        retire   = '0;
        rat_we   = '0;
        old_tag  = '0;
        n_retire = '0;
        ridx     = '0;
        state_d  = state_q;
        if (state_q == CRU_RUN) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                retire[i] = commit_valid[i] & ~exc_seen & ~commit_exception[i];
                if (commit_valid[i] & commit_exception[i]) exc_seen = 1'b1;
                rat_we[i] = retire[i] &&
                            (commit_arch_rd[i*ARCH_W +: ARCH_W] != ARCH_W'(ZERO_REG));
                n_retire  = n_retire + 32'(retire[i]);
            end
            // Intra-bundle bypass: the youngest older slot writing the same arch reg supplies the old tag.
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                old_tag[i*PREG_W +: PREG_W] = rat_rdata[i*PREG_W +: PREG_W];
                for (int j = 0; j < ISSUE_WIDTH; j++) begin
                    if (j < i && rat_we[j] &&
                        commit_arch_rd[j*ARCH_W +: ARCH_W] == commit_arch_rd[i*ARCH_W +: ARCH_W])
                        old_tag[i*PREG_W +: PREG_W] = commit_phys_rd[j*PREG_W +: PREG_W];
                end
            end
            if (exc_seen) state_d = CRU_RECOVER;
        end else begin
            for (int l = 0; l < RESTORE_PER_CYC; l++)
                ridx[l*ARCH_W +: ARCH_W] = ARCH_W'(int'(beat_q) * RESTORE_PER_CYC + l);
            if (last_beat_shown) state_d = CRU_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= CRU_RUN;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q        <= '0;
            free_valid    <= '0;
            free_tag      <= '0;
            flush_req     <= 1'b0;
            recover_busy  <= 1'b0;
            restore_valid <= 1'b0;
            restore_idx   <= '0;
            restore_tag   <= '0;
            retired_count <= '0;
        end else begin
            flush_req  <= 1'b0;
            free_valid <= '0;
            if (state_q == CRU_RUN) begin
                free_valid    <= rat_we;
                free_tag      <= old_tag;
                retired_count <= retired_count + n_retire;
                restore_valid <= 1'b0;
                if (exc_seen) begin
                    flush_req    <= 1'b1;
                    recover_busy <= 1'b1;
                    beat_q       <= '0;
                end
            end else if (last_beat_shown) begin
                restore_valid <= 1'b0;
                recover_busy  <= 1'b0;
            end else begin
                restore_valid <= 1'b1;
                restore_idx   <= ridx;
                restore_tag   <= rtag;
                recover_busy  <= 1'b1;
                beat_q        <= beat_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_retire_unit.sv
// Directed self-checking bench for commit_retire_unit.
module tb_commit_retire_unit;
    import core_pkg::*;

    logic                                clk;
    logic                                reset;
    logic [ISSUE_WIDTH-1:0]              commit_valid;
    logic [ISSUE_WIDTH*ARCH_W-1:0]       commit_arch_rd;
    logic [ISSUE_WIDTH*PREG_W-1:0]       commit_phys_rd;
    logic [ISSUE_WIDTH-1:0]              commit_exception;
    logic [ISSUE_WIDTH-1:0]              free_valid;
    logic [ISSUE_WIDTH*PREG_W-1:0]       free_tag;
    logic                                flush_req;
    logic                                recover_busy;
    logic                                restore_valid;
    logic [RESTORE_PER_CYC*ARCH_W-1:0]   restore_idx;
    logic [RESTORE_PER_CYC*PREG_W-1:0]   restore_tag;
    logic [31:0]                         retired_count;
    logic                                dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rat [NUM_ARCH_REGS];

    commit_retire_unit dut (
        .clk              (clk),
        .reset            (reset),
        .commit_valid     (commit_valid),
        .commit_arch_rd   (commit_arch_rd),
        .commit_phys_rd   (commit_phys_rd),
        .commit_exception (commit_exception),
        .free_valid       (free_valid),
        .free_tag         (free_tag),
        .flush_req        (flush_req),
        .recover_busy     (recover_busy),
        .restore_valid    (restore_valid),
        .restore_idx      (restore_idx),
        .restore_tag      (restore_tag),
        .retired_count    (retired_count),
        .dbg_state        (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] v, input logic [1:0] e,
                         input int a0, input int p0, input int a1, input int p1);
        commit_valid     = v;
        commit_exception = e;
        commit_arch_rd   = {5'(a1), 5'(a0)};
        commit_phys_rd   = {6'(p1), 6'(p0)};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_identity();
        for (int i = 0; i < NUM_ARCH_REGS; i++) exp_rat[i] = i;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        model_identity();
        repeat (3) @(posedge clk);
        #1;
        if (free_valid !== 2'b00) begin $display("FAIL reset_free_valid got %b exp 00", free_valid); n_fail++; end
        n_checks++;
        if (flush_req !== 1'b0 || recover_busy !== 1'b0 || restore_valid !== 1'b0) begin
            $display("FAIL reset_ctrl got flush=%b busy=%b rv=%b exp 0 0 0", flush_req, recover_busy, restore_valid); n_fail++;
        end
        n_checks++;
        if (retired_count !== 32'd0) begin $display("FAIL reset_count got %0d exp 0", retired_count); n_fail++; end
        n_checks++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        drive(2'b11, 2'b00, 1, 10, 2, 11);
        step();
        idle();
        exp_rat[1] = 10; exp_rat[2] = 11;
        if (free_valid !== 2'b11) begin $display("FAIL basic_free_valid got %b exp 11", free_valid); n_fail++; end
        n_checks++;
        if (free_tag !== {6'd2, 6'd1}) begin $display("FAIL basic_free_tag got %h exp %h", free_tag, {6'd2, 6'd1}); n_fail++; end
        n_checks++;
        if (retired_count !== 32'd2) begin $display("FAIL basic_count got %0d exp 2", retired_count); n_fail++; end
        n_checks++;
    endtask

    task automatic test_same_dest();
        drive(2'b11, 2'b00, 3, 12, 3, 13);
        step();
        idle();
        exp_rat[3] = 13;
        if (free_tag[5:0] !== 6'd3) begin $display("FAIL samedest_tag0 got %0d exp 3", free_tag[5:0]); n_fail++; end
        n_checks++;
        if (free_tag[11:6] !== 6'd12) begin $display("FAIL samedest_tag1 got %0d exp 12", free_tag[11:6]); n_fail++; end
        n_checks++;
        if (free_valid !== 2'b11 || retired_count !== 32'd4) begin
            $display("FAIL samedest_fv_count got fv=%b cnt=%0d exp 11 4", free_valid, retired_count); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_xzr();
        drive(2'b01, 2'b00, 31, 20, 9, 9);
        step();
        idle();
        if (free_valid !== 2'b00) begin $display("FAIL xzr_free_valid got %b exp 00", free_valid); n_fail++; end
        n_checks++;
        if (retired_count !== 32'd5) begin $display("FAIL xzr_count got %0d exp 5", retired_count); n_fail++; end
        n_checks++;
    endtask

    // Call in the flush cycle; checks 16 beats against exp_rat and the busy drop after.
    task automatic test_restore_stream(input string name);
        for (int k = 0; k < NUM_BEATS; k++) begin
            step();
            if (restore_valid !== 1'b1 || recover_busy !== 1'b1 || flush_req !== 1'b0 || free_valid !== 2'b00) begin
                $display("FAIL %s_beat%0d_ctrl got rv=%b busy=%b flush=%b fv=%b exp 1 1 0 00",
                         name, k, restore_valid, recover_busy, flush_req, free_valid); n_fail++;
            end
            n_checks++;
            if (restore_idx !== {5'(2*k+1), 5'(2*k)}) begin
                $display("FAIL %s_beat%0d_idx got %h exp %h", name, k, restore_idx, {5'(2*k+1), 5'(2*k)}); n_fail++;
            end
            n_checks++;
            if (restore_tag !== {6'(exp_rat[2*k+1]), 6'(exp_rat[2*k])}) begin
                $display("FAIL %s_beat%0d_tag got %h exp %h", name, k, restore_tag,
                         {6'(exp_rat[2*k+1]), 6'(exp_rat[2*k])}); n_fail++;
            end
            n_checks++;
        end
        step();
        if (restore_valid !== 1'b0 || recover_busy !== 1'b0) begin
            $display("FAIL %s_end got rv=%b busy=%b exp 0 0", name, restore_valid, recover_busy); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_exception_slot1();
        drive(2'b11, 2'b10, 4, 14, 5, 15);
        step();
        idle();
        exp_rat[4] = 14;
        if (free_valid !== 2'b01 || free_tag[5:0] !== 6'd4) begin
            $display("FAIL exc1_free got fv=%b tag0=%0d exp 01 4", free_valid, free_tag[5:0]); n_fail++;
        end
        n_checks++;
        if (retired_count !== 32'd6) begin $display("FAIL exc1_count got %0d exp 6", retired_count); n_fail++; end
        n_checks++;
        if (flush_req !== 1'b1 || recover_busy !== 1'b1 || restore_valid !== 1'b0) begin
            $display("FAIL exc1_flush got flush=%b busy=%b rv=%b exp 1 1 0", flush_req, recover_busy, restore_valid); n_fail++;
        end
        n_checks++;
        test_restore_stream("exc1");
    endtask

    task automatic test_exception_slot0_and_ignore();
        drive(2'b11, 2'b01, 6, 16, 6, 16);
        step();
        if (free_valid !== 2'b00 || retired_count !== 32'd6 || flush_req !== 1'b1) begin
            $display("FAIL exc0_drop got fv=%b cnt=%0d flush=%b exp 00 6 1", free_valid, retired_count, flush_req); n_fail++;
        end
        n_checks++;
        // Commits held throughout recovery must be ignored.
        drive(2'b11, 2'b00, 1, 30, 7, 31);
        test_restore_stream("exc0");
        idle();
        if (retired_count !== 32'd6) begin $display("FAIL exc0_count_after got %0d exp 6", retired_count); n_fail++; end
        n_checks++;
        drive(2'b01, 2'b00, 8, 40, 0, 0);
        step();
        idle();
        exp_rat[8] = 40;
        if (free_valid !== 2'b01 || free_tag[5:0] !== 6'd8 || retired_count !== 32'd7) begin
            $display("FAIL post_recover_commit got fv=%b tag0=%0d cnt=%0d exp 01 8 7",
                     free_valid, free_tag[5:0], retired_count); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_recover();
        drive(2'b01, 2'b01, 0, 0, 0, 0);
        step();
        idle();
        repeat (8) step();
        if (restore_valid !== 1'b1 || restore_idx !== {5'd15, 5'd14}) begin
            $display("FAIL midrst_beat7 got rv=%b idx=%h exp 1 %h", restore_valid, restore_idx, {5'd15, 5'd14}); n_fail++;
        end
        n_checks++;
        reset = 1'b0;
        #1;
        if (restore_valid !== 1'b0 || recover_busy !== 1'b0 || retired_count !== 32'd0) begin
            $display("FAIL midrst_abort got rv=%b busy=%b cnt=%0d exp 0 0 0", restore_valid, recover_busy, retired_count); n_fail++;
        end
        n_checks++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_identity();
        drive(2'b01, 2'b01, 0, 0, 0, 0);
        step();
        idle();
        if (flush_req !== 1'b1) begin $display("FAIL midrst_reflush got %b exp 1", flush_req); n_fail++; end
        n_checks++;
        test_restore_stream("identity");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_dest();
        test_xzr();
        test_exception_slot1();
        test_exception_slot0_and_ignore();
        test_reset_mid_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
